line_buffer_feeder: RTL and testbench

//  Write-side driver for the 3-row conv line buffer. Scans an IMG_H x IMG_W image in pixel memory in 3-row bands.
//  Per band it visits columns left to right. For each column it fetches one pixel from each of the three rows
//  (1-cycle read latency), then issues one combined write+shift to the line buffer.

---
 rtl/line_buffer_feeder.sv | 163 ++++++++++++++++
 tb/tb_line_buffer_feeder.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/line_buffer_feeder.sv
// Write-side driver for the 3-row conv line buffer: scans the image in 3-row bands, one column per 5 cycles.
// Optional one-pixel zero border when LB_FEEDER_ZERO_PAD_EN is defined.
module line_buffer_feeder #(
  parameter int BIT_DEPTH = 8,
  parameter int IMG_W     = 8,
  parameter int IMG_H     = 8,
  parameter int ADDR_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  output logic                 busy,
  output logic                 done,
  output logic                 mem_rd_en,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [BIT_DEPTH-1:0] mem_rd_data,
  output logic                 lb_wr_en,
  output logic                 lb_shift,
  output logic [BIT_DEPTH-1:0] lb_data_r1,
  output logic [BIT_DEPTH-1:0] lb_data_r2,
  output logic [BIT_DEPTH-1:0] lb_data_r3,
  output logic                 win_valid
);

`ifdef LB_FEEDER_ZERO_PAD_EN
  localparam int PAD = 1;
`else
  localparam int PAD = 0;
`endif
  localparam int COLS  = IMG_W + 2 * PAD;
  localparam int BANDS = (PAD == 1) ? IMG_H : IMG_H - 2;
  localparam int CW    = $clog2(COLS + 1);
  localparam int RW    = $clog2(BANDS + 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_PUSH, S_DONE} state_t;

  state_t                state, state_nxt;
  logic [ADDR_W-1:0]     base_q;
  logic [RW-1:0]         row;
  logic [CW-1:0]         col;
  logic [1:0]            sub;
  logic [BIT_DEPTH-1:0]  hold0, hold1;
  logic                  rd_pend;
  logic [BIT_DEPTH-1:0]  cap;
  logic                  in_img;
  logic [31:0]           row_l, col_l, row_a, col_a;
  logic [ADDR_W-1:0]     addr_calc;
  logic                  last_col, last_band;

  assign last_col  = (col == CW'(COLS - 1));
  assign last_band = (row == RW'(BANDS - 1));
  // Slots that were not read (padding) contribute zero.
  assign cap       = rd_pend ? mem_rd_data : '0;

  always_comb begin
    row_l = 32'(row) + 32'(sub);
    col_l = 32'(col);
`ifdef LB_FEEDER_ZERO_PAD_EN
    in_img = (row_l >= 32'd1) && (row_l <= 32'(IMG_H)) &&
             (col_l >= 32'd1) && (col_l <= 32'(IMG_W));
    row_a  = row_l - 32'd1;
    col_a  = col_l - 32'd1;
`else
    in_img = 1'b1;
    row_a  = row_l;
    col_a  = col_l;
`endif
    addr_calc = base_q + ADDR_W'(row_a * 32'(IMG_W)) + ADDR_W'(col_a);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    mem_rd_en = 1'b0;
    mem_addr  = '0;
    lb_wr_en  = 1'b0;
    lb_shift  = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nxt = S_FETCH;
      S_FETCH: begin
        busy      = 1'b1;
        mem_rd_en = in_img;
        mem_addr  = in_img ? addr_calc : '0;
        if (sub == 2'd2) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        busy      = 1'b1;
        state_nxt = S_PUSH;
      end
      S_PUSH: begin
        busy      = 1'b1;
        lb_wr_en  = 1'b1;
        lb_shift  = 1'b1;
        state_nxt = (last_col && last_band) ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q     <= '0;
      row        <= '0;
      col        <= '0;
      sub        <= '0;
      hold0      <= '0;
      hold1      <= '0;
      rd_pend    <= 1'b0;
      lb_data_r1 <= '0;
      lb_data_r2 <= '0;
      lb_data_r3 <= '0;
      win_valid  <= 1'b0;
    end else begin
      rd_pend   <= mem_rd_en;
      // Band-local push count is col+1, so the third push is col==2.
      win_valid <= (state == S_PUSH) && (col >= CW'(2));
      case (state)
        S_IDLE: if (start) begin
          base_q <= base_addr;
          row    <= '0;
          col    <= '0;
          sub    <= '0;
        end
        S_FETCH: begin
          if (sub == 2'd1) hold0 <= cap;
          if (sub == 2'd2) begin
            hold1 <= cap;
            sub   <= '0;
          end else begin
            sub <= sub + 2'd1;
          end
        end
        // The third row's pixel goes straight to the output register.
        S_WAIT: begin
          lb_data_r1 <= hold0;
          lb_data_r2 <= hold1;
          lb_data_r3 <= cap;
        end
        S_PUSH: begin
          if (last_col) begin
            col <= '0;
            if (!last_band) row <= row + RW'(1);
          end else begin
            col <= col + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_line_buffer_feeder.sv
// Directed bench for line_buffer_feeder on a 4x4 image; expectations follow LB_FEEDER_ZERO_PAD_EN.
module tb_line_buffer_feeder;
  localparam int BD = 8, IW = 4, IH = 4, AW = 16;

`ifdef LB_FEEDER_ZERO_PAD_EN
  localparam int N_PUSH = 24, LAST_PUSH = 120, DONE_AT = 121, N_WIN = 16;
  localparam int WIN2 = 26, WIN3 = 31, FIRST_RD = 7, WRAP2 = 32'hFFFF;
  localparam int FIRST_DAT = 32'h000000, SECOND_DAT = 32'h000004, LAST_DAT = 32'h000000;
`else
  localparam int N_PUSH = 8, LAST_PUSH = 40, DONE_AT = 41, N_WIN = 4;
  localparam int WIN2 = 36, WIN3 = 41, FIRST_RD = 1, WRAP2 = 32'h0006;
  localparam int FIRST_DAT = 32'h000408, SECOND_DAT = 32'h010509, LAST_DAT = 32'h070B0F;
`endif

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          busy, done, mem_rd_en, lb_wr_en, lb_shift, win_valid;
  logic [AW-1:0] mem_addr;
  logic [BD-1:0] mem_rd_data = '0;
  logic [BD-1:0] lb_data_r1, lb_data_r2, lb_data_r3;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, c0 = 0, done_cyc;
  int push_cyc[$], push_dat[$], win_cyc[$], rd_cyc[$], rd_addr[$];

  line_buffer_feeder #(.BIT_DEPTH(BD), .IMG_W(IW), .IMG_H(IH), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rd_data(mem_rd_data), .lb_wr_en(lb_wr_en), .lb_shift(lb_shift),
    .lb_data_r1(lb_data_r1), .lb_data_r2(lb_data_r2), .lb_data_r3(lb_data_r3),
    .win_valid(win_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pixel memory: mem[i] = i (low byte of the address), one-cycle read latency.
  always @(posedge clk) mem_rd_data <= mem_rd_en ? mem_addr[7:0] : 8'h00;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (lb_wr_en) begin
        push_cyc.push_back(cyc - c0);
        push_dat.push_back(int'({lb_data_r1, lb_data_r2, lb_data_r3}));
        chk("shift_eq_wr", int'(lb_shift), 1);
      end
      if (win_valid) win_cyc.push_back(cyc - c0);
      if (mem_rd_en) begin
        rd_cyc.push_back(cyc - c0);
        rd_addr.push_back(int'(mem_addr));
      end
    end
  end

  task automatic clear_logs();
    push_cyc.delete(); push_dat.delete(); win_cyc.delete();
    rd_cyc.delete(); rd_addr.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_ctl"}, int'({busy, done, mem_rd_en, lb_wr_en, lb_shift, win_valid}), 0);
    chk({tag, "_addr"}, int'(mem_addr), 0);
    chk({tag, "_data"}, int'({lb_data_r1, lb_data_r2, lb_data_r3}), 0);
  endtask

  // Called at the negedge of the start cycle; start is dropped next cycle.
  task automatic wait_done(input int extra_start, input int busy_at);
    done_cyc = -1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      start = ((cyc - c0) == extra_start);
      if ((cyc - c0) == busy_at) chk("busy_mid", int'(busy), 1);
      if (done) begin
        done_cyc = cyc - c0;
        chk("busy_at_done", int'(busy), 0);
        break;
      end
    end
    if (done_cyc < 0) chk("done_timeout", 0, 1);
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic launch(input logic [AW-1:0] base);
    base_addr = base;
    clear_logs();
    start = 1'b1;
    c0 = cyc;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("post_reset");

    // Full scan, with an ignored start pulse at cycle 12.
    launch(16'h0000);
    wait_done(12, 1);
    chk("done_cycle", done_cyc, DONE_AT);
    chk("push_count", push_cyc.size(), N_PUSH);
    chk("first_push_cyc", (push_cyc.size() > 0) ? push_cyc[0] : -1, 5);
    chk("first_push_dat", (push_dat.size() > 0) ? push_dat[0] : -1, FIRST_DAT);
    chk("second_push_dat", (push_dat.size() > 1) ? push_dat[1] : -1, SECOND_DAT);
    chk("last_push_cyc", (push_cyc.size() > 0) ? push_cyc[push_cyc.size()-1] : -1, LAST_PUSH);
    chk("last_push_dat", (push_dat.size() > 0) ? push_dat[push_dat.size()-1] : -1, LAST_DAT);
    chk("first_rd_cyc", (rd_cyc.size() > 0) ? rd_cyc[0] : -1, FIRST_RD);
    chk("win_count", win_cyc.size(), N_WIN);
    chk("win0", (win_cyc.size() > 0) ? win_cyc[0] : -1, 16);
    chk("win1", (win_cyc.size() > 1) ? win_cyc[1] : -1, 21);
    chk("win2", (win_cyc.size() > 2) ? win_cyc[2] : -1, WIN2);
    chk("win3", (win_cyc.size() > 3) ? win_cyc[3] : -1, WIN3);
    repeat (3) @(negedge clk);
    chk("idle_after_done", int'({busy, done, mem_rd_en, lb_wr_en}), 0);

    // Address wrap from base 0xFFFE.
    launch(16'hFFFE);
    wait_done(-1, -1);
    chk("wrap_addr0", (rd_addr.size() > 0) ? rd_addr[0] : -1, 32'hFFFE);
    chk("wrap_addr1", (rd_addr.size() > 1) ? rd_addr[1] : -1, 32'h0002);
    chk("wrap_addr2", (rd_addr.size() > 2) ? rd_addr[2] : -1, WRAP2);

    // Reset in the middle of a scan, then restart at cycle 16.
    launch(16'h0000);
    repeat (12) @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_rel_cycle", cyc - c0, 13);
    check_idle_outputs("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    clear_logs();
    start = 1'b1;
    chk("restart_cycle", cyc - c0, 16);
    wait_done(-1, -1);
    chk("rst_first_push_cyc", (push_cyc.size() > 0) ? push_cyc[0] : -1, 21);
    chk("rst_first_push_dat", (push_dat.size() > 0) ? push_dat[0] : -1, FIRST_DAT);
    chk("rst_push_count", push_cyc.size(), N_PUSH);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
